fifo_fc: RTL and testbench

FIFO_FC -- requirements
Module: fifo_fc

---
 rtl/fc_pkg.sv | 25 ++
 rtl/fifo_mem.sv | 53 +++++
 rtl/fifo_fc.sv | 197 +++++++++++++++++++
 tb/tb_fifo_fc.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/fc_pkg.sv
// ============================================================================
// Module      : fc_pkg
// Description : Shared definitions for the FIFO and its flow-control partner:
//               FSM state encoding and default data/depth constants.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fc_pkg;

  localparam int FC_WIDTH = 6;   // default data word width
  localparam int FC_DEPTH = 8;   // default number of entries
  localparam int FC_PTR   = 3;   // log2(FC_DEPTH)

  typedef enum logic [1:0] {
    ST_RESET  = 2'b00,
    ST_INIT   = 2'b01,
    ST_ACTIVE = 2'b10,
    ST_ERROR  = 2'b11
  } fifo_state_e;

endpackage : fc_pkg

`default_nettype wire

// File: rtl/fifo_mem.sv
// ============================================================================
// Module      : fifo_mem
// Description : DEPTH x WIDTH register array, synchronous write and
//               registered read. The read register clears on reset and holds
//               its value on cycles without a read.
// Ports       : clk, reset (sync, active-low)
//               wr_en_i / wr_addr_i / wr_data_i  - write port
//               rd_en_i / rd_addr_i              - read request
//               rd_data_o                        - registered read data
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_mem
  import fc_pkg::*;
#(
  parameter int WIDTH = FC_WIDTH,
  parameter int DEPTH = FC_DEPTH,
  parameter int PTR   = FC_PTR
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en_i,
  input  logic [PTR-1:0]   wr_addr_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  input  logic [PTR-1:0]   rd_addr_i,
  output logic [WIDTH-1:0] rd_data_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rd_data_q;

  // Storage array carries no reset; validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_data_q <= '0;
    end else if (rd_en_i) begin
      rd_data_q <= mem_q[rd_addr_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule : fifo_mem

`default_nettype wire

// File: rtl/fifo_fc.sv
// ============================================================================
// Module      : fifo_fc
// Description : Synchronous FIFO with programmable almost-full/almost-empty
//               thresholds, flow-control pause input and sticky error state.
//               Optional build macro FIFO_ERR_CNT_EN adds an 8-bit saturating
//               overflow/underflow event counter on output err_cnt.
// Ports       : clk, reset (sync, active-low)
//               iniciar, umbral_alto, umbral_bajo - start pulse and thresholds
//               push, data_in, pop, continuar     - write / read / pause
//               data_out, valid_out               - registered read data
//               full, almost_full, empty, almost_empty, error - status
//               err_cnt (FIFO_ERR_CNT_EN only)    - error event count
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_fc
  import fc_pkg::*;
#(
  parameter int WIDTH = FC_WIDTH,
  parameter int DEPTH = FC_DEPTH,
  parameter int PTR   = FC_PTR
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             iniciar,
  input  logic [PTR:0]     umbral_alto,
  input  logic [PTR:0]     umbral_bajo,
  input  logic             push,
  input  logic [WIDTH-1:0] data_in,
  input  logic             pop,
  input  logic             continuar,
  output logic [WIDTH-1:0] data_out,
  output logic             valid_out,
  output logic             full,
  output logic             almost_full,
  output logic             empty,
  output logic             almost_empty,
  output logic             error
`ifdef FIFO_ERR_CNT_EN
  ,
  output logic [7:0]       err_cnt
`endif
);

  localparam logic [PTR:0] C_DEPTH = (PTR+1)'(DEPTH);

  fifo_state_e    state_q, state_d;
  logic [PTR-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR:0]   count_q, count_d;
  logic [PTR:0]   hi_q, hi_d, lo_q, lo_d;
  logic           valid_q, valid_d;
  logic           error_q, error_d;
  logic           full_q, full_d, afull_q, afull_d;
  logic           empty_q, empty_d, aempty_q, aempty_d;

  logic           w_wr_ok, w_rd_ok, w_ovf, w_unf, w_flag_upd;

  // Raw request classification; state gating is applied where they are used.
  always_comb begin
    w_ovf   = push && (count_q == C_DEPTH);
    w_unf   = pop && continuar && (count_q == '0);
    w_wr_ok = (state_q == ST_ACTIVE) && push && (count_q != C_DEPTH);
    w_rd_ok = (state_q == ST_ACTIVE) && pop && continuar && (count_q != '0);
  end

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    full_d     = full_q;
    afull_d    = afull_q;
    empty_d    = empty_q;
    aempty_d   = aempty_q;
    w_flag_upd = 1'b0;
    valid_d    = w_rd_ok;

    case (state_q)
      ST_RESET: state_d = ST_INIT;
      ST_INIT: begin
        if (iniciar) begin
          state_d    = ST_ACTIVE;
          hi_d       = umbral_alto;
          lo_d       = umbral_bajo;
          w_flag_upd = 1'b1;
        end
      end
      ST_ACTIVE: begin
        w_flag_upd = 1'b1;
        // Pointers wrap naturally because DEPTH is a power of two.
        if (w_wr_ok) wr_ptr_d = wr_ptr_q + 1'b1;
        if (w_rd_ok) rd_ptr_d = rd_ptr_q + 1'b1;
        case ({w_wr_ok, w_rd_ok})
          2'b10:   count_d = count_q + 1'b1;
          2'b01:   count_d = count_q - 1'b1;
          default: count_d = count_q;
        endcase
        if (w_ovf || w_unf) state_d = ST_ERROR;
      end
      ST_ERROR: state_d = ST_ERROR;
      default:  state_d = ST_RESET;
    endcase

    // Flags follow the post-update count; a threshold of 0 or above DEPTH
    // disables its almost-flag.
    if (w_flag_upd) begin
      full_d   = (count_d == C_DEPTH);
      empty_d  = (count_d == '0);
      afull_d  = (hi_d != '0) && (hi_d <= C_DEPTH) && (count_d >= hi_d);
      aempty_d = (lo_d != '0) && (lo_d <= C_DEPTH) && (count_d <= lo_d);
    end

    error_d = (state_d == ST_ERROR);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= ST_RESET;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      valid_q  <= 1'b0;
      error_q  <= 1'b0;
      full_q   <= 1'b0;
      afull_q  <= 1'b0;
      empty_q  <= 1'b1;
      aempty_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      valid_q  <= valid_d;
      error_q  <= error_d;
      full_q   <= full_d;
      afull_q  <= afull_d;
      empty_q  <= empty_d;
      aempty_q <= aempty_d;
    end
  end

  // Write and read are qualified with reset so a reset cycle overrides them.
  fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .PTR   (PTR)
  ) u_mem (
    .clk       (clk),
    .reset     (reset),
    .wr_en_i   (w_wr_ok && reset),
    .wr_addr_i (wr_ptr_q),
    .wr_data_i (data_in),
    .rd_en_i   (w_rd_ok && reset),
    .rd_addr_i (rd_ptr_q),
    .rd_data_o (data_out)
  );

  assign valid_out    = valid_q;
  assign error        = error_q;
  assign full         = full_q;
  assign almost_full  = afull_q;
  assign empty        = empty_q;
  assign almost_empty = aempty_q;

`ifdef FIFO_ERR_CNT_EN
  logic [7:0] err_cnt_q, err_cnt_d;

  // Events keep counting while parked in ERROR (count is frozen there).
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (((state_q == ST_ACTIVE) || (state_q == ST_ERROR)) && (w_ovf || w_unf)
        && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_cnt = err_cnt_q;
`endif

endmodule : fifo_fc

`default_nettype wire

// File: tb/tb_fifo_fc.sv
// ============================================================================
// Module      : tb_fifo_fc
// Description : Self-checking bench for fifo_fc. A queue-based reference
//               model predicts every registered output each cycle.
//               Honours FIFO_ERR_CNT_EN when the design is built with it.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fifo_fc;

  localparam int WIDTH = 6;
  localparam int DEPTH = 8;
  localparam int PTR   = 3;

  logic             clk = 1'b0;
  logic             reset, iniciar, push, pop, continuar;
  logic [PTR:0]     umbral_alto, umbral_bajo;
  logic [WIDTH-1:0] data_in, data_out;
  logic             valid_out, full, almost_full, empty, almost_empty, error;
`ifdef FIFO_ERR_CNT_EN
  logic [7:0]       err_cnt;
`endif

  always #5 clk = ~clk;

  fifo_fc #(.WIDTH(WIDTH), .DEPTH(DEPTH), .PTR(PTR)) dut (
    .clk          (clk),
    .reset        (reset),
    .iniciar      (iniciar),
    .umbral_alto  (umbral_alto),
    .umbral_bajo  (umbral_bajo),
    .push         (push),
    .data_in      (data_in),
    .pop          (pop),
    .continuar    (continuar),
    .data_out     (data_out),
    .valid_out    (valid_out),
    .full         (full),
    .almost_full  (almost_full),
    .empty        (empty),
    .almost_empty (almost_empty),
    .error        (error)
`ifdef FIFO_ERR_CNT_EN
    ,
    .err_cnt      (err_cnt)
`endif
  );

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference model: phase 0 = just reset, 1 = waiting for start,
  // 2 = running, 3 = failed.
  logic [WIDTH-1:0] q[$];
  int               phase;
  int               m_hi, m_lo, m_ecnt;
  logic [WIDTH-1:0] m_dout;
  bit               m_valid, m_err, m_full, m_af, m_empty, m_ae;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_flags();
    int n = q.size();
    m_full  = (n == DEPTH);
    m_empty = (n == 0);
    m_af    = (m_hi >= 1) && (m_hi <= DEPTH) && (n >= m_hi);
    m_ae    = (m_lo >= 1) && (m_lo <= DEPTH) && (n <= m_lo);
  endtask

  task automatic model_step(input bit rst_n, input bit ini, input bit ps, input bit pp,
                            input bit ct, input logic [WIDTH-1:0] din,
                            input int hi, input int lo);
    int n;
    bit bad;
    m_valid = 1'b0;
    if (!rst_n) begin
      q.delete();
      phase  = 0;
      m_dout = '0;
      m_err  = 0; m_full = 0; m_af = 0; m_empty = 1; m_ae = 1;
      m_hi   = 0; m_lo = 0; m_ecnt = 0;
    end else begin
      n   = q.size();
      bad = (ps && n == DEPTH) || (pp && ct && n == 0);
      case (phase)
        0: phase = 1;
        1: if (ini) begin
             m_hi = hi; m_lo = lo; phase = 2;
             model_flags();
           end
        2: begin
             if (pp && ct && n > 0) begin
               m_dout  = q.pop_front();
               m_valid = 1'b1;
             end
             if (ps && n < DEPTH) q.push_back(din);
             if (bad) begin
               phase = 3;
               m_err = 1;
             end
             model_flags();
           end
        default: ;
      endcase
      if (bad && phase == 3 && m_ecnt < 255) m_ecnt++;
    end
  endtask

  task automatic step(input string tag, input bit rst_n, input bit ini, input bit ps,
                      input bit pp, input bit ct, input logic [WIDTH-1:0] din,
                      input int hi = 0, input int lo = 0);
    @(negedge clk);
    reset       = rst_n;
    iniciar     = ini;
    push        = ps;
    pop         = pp;
    continuar   = ct;
    data_in     = din;
    umbral_alto = (PTR+1)'(hi);
    umbral_bajo = (PTR+1)'(lo);
    model_step(rst_n, ini, ps, pp, ct, din, hi, lo);
    @(posedge clk);
    #1;
    check({tag, ".valid"}, 32'(valid_out), 32'(m_valid));
    check({tag, ".dout"}, 32'(data_out), 32'(m_dout));
    check({tag, ".error"}, 32'(error), 32'(m_err));
    check({tag, ".full"}, 32'(full), 32'(m_full));
    check({tag, ".afull"}, 32'(almost_full), 32'(m_af));
    check({tag, ".empty"}, 32'(empty), 32'(m_empty));
    check({tag, ".aempty"}, 32'(almost_empty), 32'(m_ae));
`ifdef FIFO_ERR_CNT_EN
    check({tag, ".errcnt"}, 32'(err_cnt), 32'(m_ecnt));
`endif
  endtask

  // Reset, one settle cycle, then start with the given thresholds.
  task automatic restart(input int hi, input int lo);
    step("rst", 0, 0, 0, 0, 0, '0);
    step("rst2", 0, 0, 1, 1, 1, 6'h15);
    step("post_rst", 1, 0, 0, 0, 0, '0);
    step("idle_push", 1, 0, 1, 0, 0, 6'h3F);   // ignored before start
    step("start", 1, 1, 0, 0, 0, '0, hi, lo);
  endtask

  initial begin
    reset = 0; iniciar = 0; push = 0; pop = 0; continuar = 0;
    data_in = '0; umbral_alto = '0; umbral_bajo = '0;

    // Basic start-up, six pushes then six pops in order.
    restart(6, 2);
    for (int i = 1; i <= 6; i++) step("push6", 1, 0, 1, 0, 0, WIDTH'(i));
    for (int i = 0; i < 6; i++)  step("pop6", 1, 0, 0, 1, 1, '0);

    // Fill, paused pops, then overflow.
    for (int i = 0; i < 8; i++) step("fill", 1, 0, 1, 0, 0, WIDTH'(8'h10 + i));
    for (int i = 0; i < 3; i++) step("pause", 1, 0, 0, 1, 0, '0);
    step("overflow", 1, 0, 1, 0, 0, 6'h33);
    step("err_hold", 1, 0, 1, 1, 1, 6'h34);
    step("err_hold2", 1, 0, 0, 0, 0, '0);

    // Simultaneous push/pop at count 4 with wrap-around.
    restart(6, 2);
    for (int i = 0; i < 4; i++)  step("pre4", 1, 0, 1, 0, 0, WIDTH'(i + 1));
    for (int i = 0; i < 13; i++) step("pushpop", 1, 0, 1, 1, 1, WIDTH'(8'h2A + i));
    for (int i = 0; i < 4; i++)  step("drain", 1, 0, 0, 1, 1, '0);
    step("underflow", 1, 0, 0, 1, 1, '0);
    step("err_idle", 1, 0, 0, 0, 0, '0);
    step("rst_mid", 0, 0, 1, 1, 1, 6'h2B);

    // Zero almost-full threshold disables that flag.
    restart(0, 3);
    for (int i = 0; i < 8; i++) step("fill_thr0", 1, 0, 1, 0, 0, WIDTH'(i));

    // Out-of-range thresholds.
    restart(12, 9);
    for (int i = 0; i < 8; i++) step("fill_thr_big", 1, 0, 1, 0, 0, WIDTH'(i));

    // Randomized traffic with occasional resets and restarts.
    restart(5, 3);
    for (int i = 0; i < 1500; i++) begin
      bit rs, ini, ps, pp, ct;
      rs  = ($urandom_range(0, 199) != 0);
      ini = ($urandom_range(0, 4) == 0);
      ps  = ($urandom_range(0, 99) < 50);
      pp  = ($urandom_range(0, 99) < 45);
      ct  = ($urandom_range(0, 99) < 80);
      step("rand", rs, ini, ps, pp, ct, WIDTH'($urandom),
           int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule : tb_fifo_fc

`default_nettype wire
